// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 64'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; drop the low two bits of any target.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/adder64.sv
// Plain 64-bit adder; the carry out is discarded so sums wrap modulo 2^64.
module adder64
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, the IF/ID register and the BOOT/RUN/HALT FSM.
// fsm_state mirrors the FSM state register for observation only.
module fetch_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic                br_reg,
    input  logic [ADDR_W-1:0]   reg_target,
    input  logic                halt_req,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                if_id_valid,
    output logic                halted,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         squash_cnt,
    output logic [1:0]          fsm_state
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    adder64 u_pc_adder (
        .a   (pc),
        .b   (PC_STEP),
        .sum (pc_plus4)
    );

    // A stalled cycle never redirects; the register jump wins over a PC-relative branch.
    assign redirect    = !stall && (br_reg || br_taken);
    assign redirect_pc = align_word(br_reg ? reg_target : br_target);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_cnt   <= '0;
            squash_cnt  <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    halted      <= 1'b0;
                    state       <= ST_RUN;
                end

                ST_RUN: begin
                    if (!stall) begin
                        if (redirect) begin
                            pc          <= redirect_pc;
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                            squash_cnt  <= sat_inc32(squash_cnt);
                        end else if (halt_req) begin
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                        end else begin
                            pc          <= pc_plus4;
                            if_id_instr <= instr_in;
                            if_id_pc    <= pc;
                            if_id_valid <= 1'b1;
                            fetch_cnt   <= sat_inc32(fetch_cnt);
                        end
                        if (halt_req) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                end

                ST_HALT: begin
                    if (!stall) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (redirect) begin
                            pc         <= redirect_pc;
                            squash_cnt <= sat_inc32(squash_cnt);
                        end
                        if (!halt_req) begin
                            state  <= ST_RUN;
                            halted <= 1'b0;
                        end
                    end
                end

                default: begin
                    state       <= ST_BOOT;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        br_reg;
    logic [63:0] reg_target;
    logic        halt_req;
    logic [31:0] instr_in;
    logic [63:0] pc;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'hD503201F;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .br_reg      (br_reg),
        .reg_target  (reg_target),
        .halt_req    (halt_req),
        .instr_in    (instr_in),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt),
        .fsm_state   (fsm_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: the word at an address encodes that address.
    assign instr_in = 32'hE000_0000 ^ pc[31:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        br_reg     = 1'b0;
        reg_target = '0;
        halt_req   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},     pc,          64'd0);
        check({tag, "_instr"},  if_id_instr, {32'd0, NOP});
        check({tag, "_ifpc"},   if_id_pc,    64'd0);
        check({tag, "_valid"},  if_id_valid, 64'd0);
        check({tag, "_fcnt"},   fetch_cnt,   64'd0);
        check({tag, "_scnt"},   squash_cnt,  64'd0);
        check({tag, "_halted"}, halted,      64'd0);
        check({tag, "_state"},  fsm_state,   64'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        check_reset_state("rst");

        // Release: BOOT cycle then sequential fetch
        reset = 1'b0;
        tick();
        check("boot_pc", pc, 64'd0);
        check("boot_valid", if_id_valid, 64'd0);
        check("boot_state", fsm_state, 64'd1);
        tick();
        check("run1_pc", pc, 64'd4);
        check("run1_instr", if_id_instr, 64'hE000_0000);
        check("run1_ifpc", if_id_pc, 64'd0);
        check("run1_valid", if_id_valid, 64'd1);
        tick();
        check("run2_pc", pc, 64'd8);
        tick();
        check("run3_pc", pc, 64'd12);
        check("run3_fcnt", fetch_cnt, 64'd3);
        tick();
        check("run4_pc", pc, 64'h10);
        check("run4_ifpc", if_id_pc, 64'd12);

        // Taken branch with misaligned target
        br_taken  = 1'b1;
        br_target = 64'h41;
        tick();
        check("br_pc", pc, 64'h40);
        check("br_valid", if_id_valid, 64'd0);
        check("br_instr", if_id_instr, {32'd0, NOP});
        check("br_ifpc", if_id_pc, 64'd12);
        check("br_scnt", squash_cnt, 64'd1);
        check("br_fcnt", fetch_cnt, 64'd4);
        clear_inputs();
        tick();
        check("post_br_pc", pc, 64'h44);
        check("post_br_ifpc", if_id_pc, 64'h40);
        check("post_br_instr", if_id_instr, 64'hE000_0040);
        check("post_br_fcnt", fetch_cnt, 64'd5);

        // Stalled dual redirect is ignored
        stall      = 1'b1;
        br_reg     = 1'b1;
        reg_target = 64'h200;
        br_taken   = 1'b1;
        br_target  = 64'h80;
        tick();
        check("stall_pc", pc, 64'h44);
        check("stall_ifpc", if_id_pc, 64'h40);
        check("stall_valid", if_id_valid, 64'd1);
        check("stall_scnt", squash_cnt, 64'd1);
        check("stall_fcnt", fetch_cnt, 64'd5);
        stall = 1'b0;
        tick();
        check("brreg_pc", pc, 64'h200);
        check("brreg_scnt", squash_cnt, 64'd2);
        check("brreg_valid", if_id_valid, 64'd0);
        clear_inputs();
        tick();
        check("post_brreg_pc", pc, 64'h204);
        check("post_brreg_ifpc", if_id_pc, 64'h200);
        check("post_brreg_fcnt", fetch_cnt, 64'd6);

        // Halt at 0x20 for three cycles
        br_taken  = 1'b1;
        br_target = 64'h20;
        tick();
        check("to20_pc", pc, 64'h20);
        check("to20_scnt", squash_cnt, 64'd3);
        clear_inputs();
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_halted", halted, 64'd1);
            check("halt_pc", pc, 64'h20);
            check("halt_valid", if_id_valid, 64'd0);
            check("halt_state", fsm_state, 64'd2);
        end
        check("halt_fcnt", fetch_cnt, 64'd6);
        halt_req = 1'b0;
        tick();
        check("unhalt_halted", halted, 64'd0);
        check("unhalt_pc", pc, 64'h20);
        check("unhalt_valid", if_id_valid, 64'd0);
        tick();
        check("resume_pc", pc, 64'h24);
        check("resume_ifpc", if_id_pc, 64'h20);
        check("resume_valid", if_id_valid, 64'd1);
        check("resume_fcnt", fetch_cnt, 64'd7);

        // PC wraps past the top of the address space
        br_reg     = 1'b1;
        reg_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("top_scnt", squash_cnt, 64'd4);
        clear_inputs();
        tick();
        check("wrap_pc", pc, 64'd0);
        check("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr", if_id_instr, 64'h1FFF_FFFC);
        check("wrap_fcnt", fetch_cnt, 64'd8);

        // Counter saturation from a preloaded value
        @(negedge clk);
        force dut.fetch_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_cnt;
        tick();
        check("sat1_fcnt", fetch_cnt, 64'hFFFF_FFFF);
        tick();
        check("sat2_fcnt", fetch_cnt, 64'hFFFF_FFFF);
        check("sat2_pc", pc, 64'd8);

        // Reset while halted and stalled
        halt_req = 1'b1;
        tick();
        check("pre_rst_halted", halted, 64'd1);
        stall = 1'b1;
        reset = 1'b1;
        tick();
        check_reset_state("rst_halt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide port stall, input, 1 bit: hazard hold; PC and IF/ID frozen.
REQ-004 SHALL provide port br_taken, input, 1 bit: conditional or unconditional branch resolved taken in ID.
REQ-005 SHALL provide port br_target, input, 64 bits: PC-relative branch target.
REQ-006 SHALL provide port br_reg, input, 1 bit: register jump (BR) resolved in ID.
REQ-007 SHALL provide port reg_target, input, 64 bits: jump target from register-file Db.
REQ-008 SHALL provide port halt_req, input, 1 bit: request to stop fetching.
REQ-009 SHALL provide port instr_in, input, 32 bits: instruction-memory output for the current pc, valid in the same cycle.
REQ-010 SHALL provide port pc, output, 64 bits: registered fetch address driven to instruction memory.
REQ-011 SHALL provide port if_id_instr, output, 32 bits: IF/ID instruction register.
REQ-012 SHALL provide port if_id_pc, output, 64 bits: IF/ID PC register.
REQ-013 SHALL provide port if_id_valid, output, 1 bit: IF/ID holds a real instruction.
REQ-014 SHALL provide port halted, output, 1 bit: high while in HALT.
REQ-015 SHALL provide port fetch_cnt, output, 32 bits: count of valid IF/ID captures.
REQ-016 SHALL provide port squash_cnt, output, 32 bits: count of accepted redirects.

Function
REQ-017 SHALL implement FSM states BOOT, RUN and HALT.
REQ-018 BOOT SHALL last exactly one cycle after reset deasserts: pc held, IF/ID bubble, next state RUN.
REQ-019 A bubble SHALL be if_id_instr = NOP (32'hD503201F), if_id_valid = 0, if_id_pc unchanged.
REQ-020 Redirect SHALL mean br_reg or br_taken asserted while stall = 0; br_reg has priority over br_taken.
REQ-021 On a redirect, pc SHALL be loaded with the selected target with bits [1:0] forced to 0, and IF/ID SHALL be loaded with a bubble (one-cycle branch penalty).
REQ-022 In RUN with stall = 0, no redirect and halt_req = 0: pc <= pc + 4 (modulo 2^64, 64'hFFFF_FFFF_FFFF_FFFC wraps to 0), and IF/ID <= {instr_in, pc, valid = 1}.
REQ-023 When stall = 1 in any state other than BOOT, pc, IF/ID, FSM state and counters SHALL hold, and br_taken, br_reg and halt_req SHALL be ignored.
REQ-024 In RUN with stall = 0 and halt_req = 1: next state HALT and IF/ID bubble; pc holds unless a redirect occurs in the same cycle, in which case the redirect still loads pc.
REQ-025 In HALT with stall = 0: IF/ID bubble every cycle; pc holds except that a redirect loads pc; halt_req = 0 SHALL return the FSM to RUN on the next edge.
REQ-026 fetch_cnt SHALL increment on every capture with valid = 1; squash_cnt SHALL increment on every accepted redirect; both SHALL saturate at 32'hFFFF_FFFF.
REQ-027 halted SHALL be a decode of state == HALT (registered, no combinational input path).

Reset
REQ-028 While reset = 1: pc = 0, if_id_instr = NOP, if_id_pc = 0, if_id_valid = 0, fetch_cnt = 0, squash_cnt = 0, state = BOOT, halted = 0.
REQ-029 reset asserted mid-operation (including during stall or HALT) SHALL override all other inputs on that edge.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the state enum fetch_state_t, the constants NOP_INSTR = 32'hD503201F and PC_STEP = 64'd4, and the 64-bit address width parameter.
REQ-031 The block SHALL instantiate exactly one sub-module, the existing adder64, to compute pc + 4; all other logic SHALL be local.

Verification
REQ-032 Reset, release, stall = 0 for 4 cycles -> pc sequence 0, 0 (BOOT), 4, 8, 12; first valid capture is instr_in at pc 0; fetch_cnt = 3.
REQ-033 At pc = 0x10, br_taken = 1 with br_target = 0x41 -> next pc = 0x40, IF/ID bubble, squash_cnt + 1; the following capture has if_id_pc = 0x40.
REQ-034 br_reg = 1 with reg_target = 0x200 and br_taken = 1 with br_target = 0x80 in the same cycle -> pc = 0x200; with stall = 1 on that cycle instead -> pc, IF/ID and counters unchanged.
REQ-035 halt_req = 1 for 3 cycles at pc = 0x20 -> halted = 1, pc stays 0x20, if_id_valid = 0; deassert -> RUN, next capture at 0x20.
REQ-036 Force pc to 0xFFFF_FFFF_FFFF_FFFC by redirect -> next pc = 0; preload counter at 0xFFFF_FFFF -> stays 0xFFFF_FFFF; reset asserted during HALT -> all REQ-028 values after one edge.
